// File: rtl/sort_stream_ctrl.sv
// Collects SIZE serial samples, launches the sorter, then streams sorted (data, index) pairs out.
// Registered outputs; input stalls outside FILL, output holds while out_ready is low, WAIT aborts after TIMEOUT cycles.
module sort_stream_ctrl #(
  parameter int SIZE          = 4,
  parameter int TIMEOUT       = 1024,
  parameter int NETWORK_WIDTH = 8,
  parameter int INDEX_WIDTH   = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic [NETWORK_WIDTH-1:0]           in_data,
  output logic                               in_ready,
  output logic                               sort_reset,
  output logic                               sort_ready,
  output logic [SIZE-1:0][NETWORK_WIDTH-1:0] sort_data_in,
  output logic [SIZE-1:0][INDEX_WIDTH-1:0]   sort_index_in,
  input  logic [SIZE-1:0][NETWORK_WIDTH-1:0] sort_data_out,
  input  logic [SIZE-1:0][INDEX_WIDTH-1:0]   sort_index_out,
  input  logic                               sort_done,
  output logic                               out_valid,
  output logic [NETWORK_WIDTH-1:0]           out_data,
  output logic [INDEX_WIDTH-1:0]             out_index,
  output logic                               out_last,
  input  logic                               out_ready,
  output logic                               timeout_err
);

  localparam int KW = $clog2(SIZE);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [KW-1:0] LAST_SLOT = KW'(SIZE - 1);

  typedef enum logic [2:0] {CLEAR, FILL, LAUNCH, WAIT, DRAIN} state_t;

  state_t                            state, state_nxt;
  logic [KW-1:0]                     slot, slot_nxt;
  logic [TW-1:0]                     tcnt, tcnt_nxt;
  logic [SIZE-1:0][NETWORK_WIDTH-1:0] buf_data, buf_data_nxt;
  logic [SIZE-1:0][INDEX_WIDTH-1:0]   buf_index, buf_index_nxt;
  logic [SIZE-1:0][NETWORK_WIDTH-1:0] data_in_nxt;
  logic [SIZE-1:0][INDEX_WIDTH-1:0]   index_in_nxt;
  logic                              in_ready_nxt, sort_reset_nxt, sort_ready_nxt, timeout_err_nxt;
  logic                              out_valid_nxt, out_last_nxt;
  logic [NETWORK_WIDTH-1:0]          out_data_nxt;
  logic [INDEX_WIDTH-1:0]            out_index_nxt;

  always_comb begin
    state_nxt       = state;
    slot_nxt        = slot;
    tcnt_nxt        = tcnt;
    buf_data_nxt    = buf_data;
    buf_index_nxt   = buf_index;
    data_in_nxt     = sort_data_in;
    index_in_nxt    = sort_index_in;
    in_ready_nxt    = in_ready;
    sort_reset_nxt  = 1'b0;
    sort_ready_nxt  = 1'b0;
    timeout_err_nxt = 1'b0;
    out_valid_nxt   = out_valid;
    out_data_nxt    = out_data;
    out_index_nxt   = out_index;
    out_last_nxt    = out_last;

    case (state)
      CLEAR: begin
        state_nxt    = FILL;
        in_ready_nxt = 1'b1;
        slot_nxt     = '0;
        tcnt_nxt     = '0;
        data_in_nxt  = '0;
        index_in_nxt = '0;
      end
      FILL: begin
        if (in_valid && in_ready) begin
          data_in_nxt[slot]  = in_data;
          index_in_nxt[slot] = INDEX_WIDTH'(slot);
          slot_nxt           = slot + KW'(1);
          if (slot == LAST_SLOT) begin
            in_ready_nxt   = 1'b0;
            sort_ready_nxt = 1'b1;
            state_nxt      = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        state_nxt = WAIT;
        tcnt_nxt  = '0;
      end
      WAIT: begin
        tcnt_nxt = tcnt + TW'(1);
        // done is checked first so a result arriving on the last allowed cycle is kept
        if (sort_done) begin
          buf_data_nxt  = sort_data_out;
          buf_index_nxt = sort_index_out;
          out_valid_nxt = 1'b1;
          out_data_nxt  = sort_data_out[0];
          out_index_nxt = sort_index_out[0];
          out_last_nxt  = 1'b0;
          slot_nxt      = '0;
          state_nxt     = DRAIN;
        end else if ((TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1))) begin
          timeout_err_nxt = 1'b1;
          sort_reset_nxt  = 1'b1;
          state_nxt       = CLEAR;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (slot == LAST_SLOT) begin
            out_valid_nxt  = 1'b0;
            out_last_nxt   = 1'b0;
            sort_reset_nxt = 1'b1;
            state_nxt      = CLEAR;
          end else begin
            slot_nxt      = slot + KW'(1);
            out_data_nxt  = buf_data[slot_nxt];
            out_index_nxt = buf_index[slot_nxt];
            out_last_nxt  = (slot_nxt == LAST_SLOT);
          end
        end
      end
      default: begin
        state_nxt      = CLEAR;
        sort_reset_nxt = 1'b1;
        in_ready_nxt   = 1'b0;
        out_valid_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= CLEAR;
      slot          <= '0;
      tcnt          <= '0;
      buf_data      <= '0;
      buf_index     <= '0;
      sort_data_in  <= '0;
      sort_index_in <= '0;
      in_ready      <= 1'b0;
      sort_reset    <= 1'b1;
      sort_ready    <= 1'b0;
      timeout_err   <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_index     <= '0;
      out_last      <= 1'b0;
    end else begin
      state         <= state_nxt;
      slot          <= slot_nxt;
      tcnt          <= tcnt_nxt;
      buf_data      <= buf_data_nxt;
      buf_index     <= buf_index_nxt;
      sort_data_in  <= data_in_nxt;
      sort_index_in <= index_in_nxt;
      in_ready      <= in_ready_nxt;
      sort_reset    <= sort_reset_nxt;
      sort_ready    <= sort_ready_nxt;
      timeout_err   <= timeout_err_nxt;
      out_valid     <= out_valid_nxt;
      out_data      <= out_data_nxt;
      out_index     <= out_index_nxt;
      out_last      <= out_last_nxt;
    end
  end

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Bench for sort_stream_ctrl: a behavioural sorter stub plus a rank-based reference model of the output stream.
// Directed frames (basic, gaps, backpressure, timeout, mid-drain reset) followed by randomized frames.
`timescale 1ns/1ps
module tb_sort_stream_ctrl;

  localparam int SIZE = 4;
  localparam int NW   = 8;
  localparam int IW   = 2;
  localparam int TO   = 8;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       in_valid;
  logic [NW-1:0]              in_data;
  logic                       in_ready;
  logic                       sort_reset;
  logic                       sort_ready;
  logic [SIZE-1:0][NW-1:0]    sort_data_in;
  logic [SIZE-1:0][IW-1:0]    sort_index_in;
  logic [SIZE-1:0][NW-1:0]    sort_data_out;
  logic [SIZE-1:0][IW-1:0]    sort_index_out;
  logic                       sort_done;
  logic                       out_valid;
  logic [NW-1:0]              out_data;
  logic [IW-1:0]              out_index;
  logic                       out_last;
  logic                       out_ready;
  logic                       timeout_err;

  always #5 clk = ~clk;

  sort_stream_ctrl #(.SIZE(SIZE), .TIMEOUT(TO), .NETWORK_WIDTH(NW), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sort_reset(sort_reset), .sort_ready(sort_ready),
    .sort_data_in(sort_data_in), .sort_index_in(sort_index_in),
    .sort_data_out(sort_data_out), .sort_index_out(sort_index_out), .sort_done(sort_done),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_ready(out_ready), .timeout_err(timeout_err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Sorter stub: ascending, stable bubble sort, result sticky until sort_reset.
  logic                    stub_never = 1'b0;
  int                      stub_lat   = 2;
  logic                    pend;
  int                      lat_cnt;
  logic [SIZE-1:0][NW-1:0] launch_data;
  logic [SIZE-1:0][IW-1:0] launch_index;

  function automatic logic [SIZE*(NW+IW)-1:0] sorter(input logic [SIZE-1:0][NW-1:0] d,
                                                     input logic [SIZE-1:0][IW-1:0] ix);
    logic [SIZE-1:0][NW-1:0] dd = d;
    logic [SIZE-1:0][IW-1:0] ii = ix;
    logic [NW-1:0]           td;
    logic [IW-1:0]           ti;
    for (int p = 0; p < SIZE - 1; p++)
      for (int j = 0; j < SIZE - 1 - p; j++)
        if (dd[j] > dd[j+1]) begin
          td = dd[j]; dd[j] = dd[j+1]; dd[j+1] = td;
          ti = ii[j]; ii[j] = ii[j+1]; ii[j+1] = ti;
        end
    return {ii, dd};
  endfunction

  always @(posedge clk) begin
    if (sort_reset) begin
      sort_done      <= 1'b0;
      pend           <= 1'b0;
      sort_data_out  <= $urandom;
      sort_index_out <= (SIZE*IW)'($urandom);
    end else if (sort_ready) begin
      launch_data  <= sort_data_in;
      launch_index <= sort_index_in;
      if (!stub_never) begin
        if (stub_lat <= 1) begin
          {sort_index_out, sort_data_out} <= sorter(sort_data_in, sort_index_in);
          sort_done <= 1'b1;
        end else begin
          pend    <= 1'b1;
          lat_cnt <= stub_lat - 1;
        end
      end
    end else if (pend) begin
      if (lat_cnt == 1) begin
        pend <= 1'b0;
        {sort_index_out, sort_data_out} <= sorter(launch_data, launch_index);
        sort_done <= 1'b1;
      end
      lat_cnt <= lat_cnt - 1;
    end
  end

  // Reference model: an element's output slot is its rank among the frame (ties by arrival).
  logic [NW-1:0]     smp   [SIZE];
  logic [NW-1:0]     exp_d [SIZE];
  logic [IW-1:0]     exp_i [SIZE];
  logic [NW+IW:0]    out_q [$];

  task automatic build_expected();
    for (int i = 0; i < SIZE; i++) begin
      int r = 0;
      for (int j = 0; j < SIZE; j++)
        if (smp[j] < smp[i] || (smp[j] == smp[i] && j < i)) r++;
      exp_d[r] = smp[i];
      exp_i[r] = IW'(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_samples(input int narrow);
    for (int i = 0; i < SIZE; i++)
      smp[i] = narrow ? NW'($urandom_range(0, 7)) : NW'($urandom);
  endtask

  // Runs one frame from the current cycle; vmode: 0 steady, 1 gap pattern, 2 random.
  // rmode: 0 always ready, 1 three-cycle stall at element 2, 2 random.
  task automatic do_frame(input int vmode, input int rmode, input int exp_rst, input int stop_at);
    int            sent = 0, cyc = 0, n_ready = 0, n_rst = 0, n_err = 0;
    int            early = 0, late = 0, hold_viol = 0, held = 0;
    logic          seen_launch = 1'b0, prev_stall = 1'b0;
    logic [NW-1:0] pd = '0;
    logic [IW-1:0] pi = '0;
    logic          pl = 1'b0;
    logic [6:0]    gap_pat = 7'b1011001;
    logic [NW+IW:0] e;
    out_q.delete();
    build_expected();
    while (out_q.size() < stop_at && cyc < 300) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = gap_pat[cyc % 7];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      if (sent < SIZE) in_data = smp[sent];
      else             in_data = NW'($urandom);
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = 1'b1;
          if (out_valid && out_q.size() == 1 && held < 3) begin
            out_ready = 1'b0;
            held++;
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (sent == SIZE && in_ready) late++;
      if (in_valid && in_ready) sent++;
      if (out_valid && !seen_launch) early++;
      if (sort_ready) begin n_ready++; seen_launch = 1'b1; end
      if (sort_reset) n_rst++;
      if (timeout_err) n_err++;
      if (prev_stall && {out_data, out_index, out_last} != {pd, pi, pl}) hold_viol++;
      prev_stall = out_valid && !out_ready;
      pd = out_data; pi = out_index; pl = out_last;
      if (out_valid && out_ready) out_q.push_back({out_last, out_index, out_data});
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("frame_outputs", 32'(out_q.size()), 32'(stop_at));
    for (int i = 0; i < SIZE; i++) begin
      check("launch_data", 32'(launch_data[i]), 32'(smp[i]));
      check("launch_index", 32'(launch_index[i]), 32'(i));
    end
    for (int i = 0; i < out_q.size(); i++) begin
      e = out_q[i];
      check("out_data", 32'(e[NW-1:0]), 32'(exp_d[i]));
      check("out_index", 32'(e[NW+IW-1:NW]), 32'(exp_i[i]));
      check("out_last", 32'(e[NW+IW]), (i == SIZE - 1) ? 32'd1 : 32'd0);
    end
    check("sort_ready_pulses", 32'(n_ready), 32'd1);
    check("sort_reset_cycles", 32'(n_rst), 32'(exp_rst));
    check("no_timeout_err", 32'(n_err), 32'd0);
    check("no_early_out", 32'(early), 32'd0);
    check("in_ready_after_fill", 32'(late), 32'd0);
    check("stall_hold", 32'(hold_viol), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent, cyc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) tick();

    check("rst_sort_reset", 32'(sort_reset), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sort_ready", 32'(sort_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_sort_data_in", 32'(sort_data_in), 32'd0);
    check("rst_sort_index_in", 32'(sort_index_in), 32'd0);
    reset = 1'b0;

    // Basic frame
    smp[0] = 8'h30; smp[1] = 8'h10; smp[2] = 8'h40; smp[3] = 8'h20;
    stub_lat = 2;
    do_frame(0, 0, 1, SIZE);

    // Back-to-back: previous done is still high through the following CLEAR
    rand_samples(0);
    stub_lat = 3;
    do_frame(0, 0, 1, SIZE);

    // Input gaps
    rand_samples(0);
    do_frame(1, 0, 1, SIZE);

    // Output backpressure at element 2
    rand_samples(1);
    do_frame(0, 1, 1, SIZE);

    // Timeout: sorter never answers
    stub_never = 1'b1;
    rand_samples(0);
    sent = 0;
    cyc  = 0;
    while (!sort_ready && cyc < 100) begin
      in_valid = (sent < SIZE);
      if (sent < SIZE) in_data = smp[sent];
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("to_launch_seen", 32'(sort_ready), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("to_timeout_err", 32'(timeout_err), (k == TO + 1) ? 32'd1 : 32'd0);
      check("to_sort_reset", 32'(sort_reset), (k == TO + 1) ? 32'd1 : 32'd0);
      check("to_in_ready", 32'(in_ready), (k == TO + 2) ? 32'd1 : 32'd0);
      check("to_out_valid", 32'(out_valid), 32'd0);
    end
    stub_never = 1'b0;

    // Done on the last allowed WAIT cycle wins over the timeout
    rand_samples(0);
    stub_lat = TO;
    do_frame(0, 0, 0, SIZE);

    // Reset mid-DRAIN after the first element
    rand_samples(0);
    stub_lat = 2;
    do_frame(0, 0, 1, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sort_reset", 32'(sort_reset), 32'd1);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    check("mid_rst_sort_data_in", 32'(sort_data_in), 32'd0);
    reset = 1'b0;
    rand_samples(0);
    do_frame(2, 2, 1, SIZE);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      rand_samples(f % 2);
      stub_lat = $urandom_range(1, TO);
      do_frame($urandom_range(0, 2), $urandom_range(0, 2), 1, SIZE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sort_stream_ctrl.md
Name: sort_stream_ctrl

Overview:
- Front/back-end controller for the registered sorting network (SIZE-wide, data + index lanes, ready/done handshake).
- Collects SIZE serial samples into the parallel load vector and tags each with its arrival index.
- Launches the sorter with a one-cycle ready pulse, waits for done, then serialises the sorted data/index pairs onto a valid/ready output stream.
- Owns the sorter's reset between frames, because the sorter's done is sticky until reset.

Parameters:
- SIZE, 4, number of sorter lanes; power of two, >= 2.
- TIMEOUT, 1024, max cycles in WAIT before abort; 0 disables the timeout.
- NETWORK_WIDTH and INDEX_WIDTH come from the shared parameters header. INDEX_WIDTH >= clog2(SIZE).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_data  in  NETWORK_WIDTH  input sample.
- in_ready  out  1  controller accepts a sample this cycle.
- sort_reset  out  1  drives the sorter reset.
- sort_ready  out  1  sorter launch pulse.
- sort_data_in  out  [SIZE][NETWORK_WIDTH]  sorter data load vector.
- sort_index_in  out  [SIZE][INDEX_WIDTH]  sorter index load vector.
- sort_data_out  in  [SIZE][NETWORK_WIDTH]  sorter result data.
- sort_index_out  in  [SIZE][INDEX_WIDTH]  sorter result indices.
- sort_done  in  1  sorter result valid (sticky until sorter reset).
- out_valid  out  1  output element valid.
- out_data  out  NETWORK_WIDTH  sorted element.
- out_index  out  INDEX_WIDTH  original arrival index of that element.
- out_last  out  1  marks slot SIZE-1 of the frame.
- out_ready  in  1  downstream accepts the element.
- timeout_err  out  1  one-cycle pulse on WAIT abort.

Behaviour:
- All outputs are registered.
- Reset values: sort_reset=1, state=CLEAR. Every other output is 0, including sort_data_in/sort_index_in, slot counter, timeout counter and output buffer.
- CLEAR (1 cycle): sort_reset=1 this cycle; next state FILL; next cycle sort_reset=0 and in_ready=1.
- FILL: in_ready=1.
  - Each in_valid && in_ready handshake writes sort_data_in[k]=in_data and sort_index_in[k]=k, then k++.
  - On the handshake with k==SIZE-1: in_ready drops the next cycle and the state goes to LAUNCH.
  - in_valid with in_ready=0 is ignored; no sample is ever lost or duplicated.
- LAUNCH (1 cycle): sort_ready=1 for exactly one cycle, then WAIT.
  - sort_data_in/sort_index_in stay stable from the final FILL write until the next CLEAR.
- WAIT: timeout counter increments each cycle.
  - When sort_done=1: latch sort_data_out/sort_index_out into the output buffer, k=0, go to DRAIN.
  - If the counter reaches TIMEOUT (TIMEOUT != 0) with no sort_done: timeout_err=1 for one cycle, discard the frame, go to CLEAR.
  - If sort_done and the timeout hit on the same cycle, done wins: no error, go to DRAIN.
- DRAIN: out_valid=1, out_data=buffer data[k], out_index=buffer index[k], out_last=(k==SIZE-1).
  - Outputs hold while out_ready=0.
  - On out_valid && out_ready: k++. After the handshake at k==SIZE-1: out_valid=0, go to CLEAR.
  - Emission order is slot 0 first through slot SIZE-1. Direction is the sorter's concern.
- No frame overlap: in_ready=0 in CLEAR, LAUNCH, WAIT and DRAIN.
- sort_done while not in WAIT is ignored. It is necessarily stale before CLEAR completes.
- Reset mid-operation (any state): returns to the reset values above on the next edge. The partial frame and buffer are dropped and sort_reset is asserted.
- Minimum frame period: 1 (CLEAR) + SIZE (FILL) + 1 (LAUNCH) + sorter latency + 1 (latch) + SIZE (DRAIN), with in_valid/out_ready held high.

Test Plan:
- Basic frame (SIZE=4, NETWORK_WIDTH=8, INDEX_WIDTH=2). Feed 0x30,0x10,0x40,0x20 with continuous in_valid. Bench sorter stub returns data {0x10,0x20,0x30,0x40} and index {1,3,0,2} two cycles after sort_ready.
  - Required: sort_data_in={0x30,0x10,0x40,0x20} and sort_index_in={0,1,2,3}.
  - Required: exactly one sort_ready pulse.
  - Required: out stream (0x10,1),(0x20,3),(0x30,0),(0x40,2), with out_last only on the 4th element.
  - Required: one sort_reset pulse afterwards.
- Input gaps: in_valid toggling 1,0,0,1,1,0,1 → exactly four samples captured in order; in_ready=0 from the cycle after the 4th handshake.
- Output backpressure: out_ready low for 3 cycles at element 2 → out_data/out_index/out_last held constant; no element skipped or repeated.
- Timeout: TIMEOUT=8, stub never asserts sort_done → timeout_err pulses on cycle 8 of WAIT, then one sort_reset cycle, then in_ready=1; no out_valid.
- Reset mid-DRAIN after element 1 → next cycle out_valid=0 and sort_reset=1; a new full frame then sorts correctly.
- Back-to-back frames: two frames with out_ready=1 → second frame outputs correct; sort_reset asserted between frames; stale sort_done=1 during CLEAR causes no early DRAIN.
